// File: rtl/btn_pkg.sv
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared FSM state encoding, parameter defaults and the
//                round-robin picker for the button scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int unsigned c_PRESCALE_DEFAULT   = 50000;
    localparam int unsigned c_STABLE_CNT_DEFAULT = 4;

    // First set request at or after ptr, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
//  Module      : tick_gen
//  Description : 16-bit prescaler producing a one-cycle strobe every
//                PRESCALE clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen
    import btn_pkg::*;
#(
    parameter int unsigned PRESCALE = c_PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] c_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    // Decoded straight from the counter register; low in reset since PRESCALE >= 2.
    assign tick = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/btn_utemezo.sv
// ============================================================================
//  Module      : btn_utemezo
//  Description : Four-button debouncer sharing one stability counter and one
//                FSM, with round-robin service between held buttons.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_utemezo
    import btn_pkg::*;
#(
    parameter int unsigned PRESCALE   = c_PRESCALE_DEFAULT,
    parameter int unsigned STABLE_CNT = c_STABLE_CNT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic [3:0] press,
    output logic       tick,
    output logic       busy,
    output logic [1:0] grant
);

    localparam logic [3:0] c_CNT_LAST = 4'(STABLE_CNT - 1);

    logic [3:0] r_sync1;
    logic [3:0] r_sbtn;
    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_rr;
    logic [1:0] r_grant;
    logic [3:0] r_press;
    logic       r_busy;
    logic       w_tick;
    logic       w_held;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sbtn  <= '0;
        end else begin
            r_sync1 <= btn;
            r_sbtn  <= r_sync1;
        end
    end

    assign w_held = r_sbtn[r_grant];

    // The counter reaching STABLE_CNT is detected on the tick that would take
    // it there, so the press pulse lands in the cycle right after that tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rr    <= '0;
            r_grant <= '0;
            r_press <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_press <= '0;
            case (r_state)
                IDLE: begin
                    if (w_tick && (|r_sbtn)) begin
                        r_grant <= rr_pick(r_sbtn, r_rr);
                        r_cnt   <= 4'd1;
                        r_state <= CHECK;
                        r_busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (w_tick) begin
                        if (!w_held) begin
                            r_rr    <= r_grant + 2'd1;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_press <= 4'b0001 << r_grant;
                            r_cnt   <= '0;
                            r_state <= RELEASE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (w_tick) begin
                        if (w_held) begin
                            r_cnt <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_rr    <= r_grant + 2'd1;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign press = r_press;
    assign tick  = w_tick;
    assign busy  = r_busy;
    assign grant = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_btn_utemezo.sv
// ============================================================================
//  Module      : tb_btn_utemezo
//  Description : Directed self-checking bench for btn_utemezo
//                (PRESCALE=4, STABLE_CNT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btn_utemezo;

    localparam int unsigned c_PRESCALE   = 4;
    localparam int unsigned c_STABLE_CNT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] press;
    logic       tick;
    logic       busy;
    logic [1:0] grant;

    int n_checks  = 0;
    int n_fail    = 0;
    int press_cnt = 0;
    int multi_cnt = 0;
    int base      = 0;

    btn_utemezo #(
        .PRESCALE   (c_PRESCALE),
        .STABLE_CNT (c_STABLE_CNT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press),
        .tick  (tick),
        .busy  (busy),
        .grant (grant)
    );

    always #5 clk = ~clk;

    // Counts press pulses seen in the cycle preceding each rising edge.
    always @(posedge clk) begin
        if (rst && (press != 4'b0000)) begin
            press_cnt++;
            if ($countones(press) > 1) multi_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge where rst rises (before edge E1).
    task automatic start(input logic [3:0] b);
        @(negedge clk);
        rst = 1'b0;
        btn = 4'b0000;
        #1;
        check("reset_press", 32'(press), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_tick",  32'(tick),  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        btn  = b;
        base = press_cnt;
    endtask

    initial begin
        logic [3:0] exp_p;
        int         e;

        // Long hold on button 1: a single press, then four low ticks to idle.
        start(4'b0010);
        go(3);  check("t1_tick_e3",  32'(tick), 32'h1);
        check("t1_busy_e3", 32'(busy), 32'h0);
        go(1);  check("t1_tick_e4",  32'(tick), 32'h0);
        check("t1_busy_e4",  32'(busy),  32'h1);
        check("t1_grant_e4", 32'(grant), 32'h1);
        go(11); check("t1_press_e15", 32'(press), 32'h0);
        go(1);  check("t1_press_e16", 32'(press), 32'h2);
        go(1);  check("t1_press_e17", 32'(press), 32'h0);
        go(143);
        check("t1_press_count_hold", 32'(press_cnt - base), 32'd1);
        check("t1_busy_hold", 32'(busy), 32'h1);
        btn = 4'b0000;
        go(15); check("t1_busy_e175", 32'(busy), 32'h1);
        go(1);  check("t1_busy_e176", 32'(busy), 32'h0);
        check("t1_press_count", 32'(press_cnt - base), 32'd1);

        // Two-tick glitch on button 0 advances the pointer to 1.
        start(4'b0001);
        go(8);  check("t2_busy_e8", 32'(busy), 32'h1);
        go(1);  btn = 4'b0000;
        go(3);  check("t2_busy_e12", 32'(busy), 32'h0);
        check("t2_grant_hold", 32'(grant), 32'h0);
        check("t2_press_count", 32'(press_cnt - base), 32'd0);
        btn = 4'b0011;
        go(4);  check("t2_grant_rr", 32'(grant), 32'h1);

        // Buttons 0 and 3 together: 0 first, 3 after 0 is released.
        start(4'b1001);
        go(16); check("t3_press0", 32'(press), 32'h1);
        btn = 4'b1000;
        go(16); check("t3_busy_e32", 32'(busy), 32'h0);
        go(4);  check("t3_grant3", 32'(grant), 32'h3);
        check("t3_busy_e36", 32'(busy), 32'h1);
        go(11); check("t3_press_e47", 32'(press), 32'h0);
        go(1);  check("t3_press3", 32'(press), 32'h8);
        go(1);  check("t3_press_count", 32'(press_cnt - base), 32'd2);

        // Bounce during release restarts the low-tick count.
        start(4'b0010);
        go(16); check("t4_press", 32'(press), 32'h2);
        btn = 4'b0000;
        go(5);  btn = 4'b0010;
        go(8);  btn = 4'b0000;
        go(11); check("t4_busy_e40", 32'(busy), 32'h1);
        go(3);  check("t4_busy_e43", 32'(busy), 32'h1);
        go(1);  check("t4_busy_e44", 32'(busy), 32'h0);
        check("t4_press_count", 32'(press_cnt - base), 32'd1);

        // Reset asserted mid-check, on a tick cycle.
        start(4'b0100);
        go(15); check("t5_tick_pre", 32'(tick), 32'h1);
        check("t5_busy_pre",  32'(busy),  32'h1);
        check("t5_grant_pre", 32'(grant), 32'h2);
        rst = 1'b0;
        #1;
        check("t5_async_tick",  32'(tick),  32'h0);
        check("t5_async_busy",  32'(busy),  32'h0);
        check("t5_async_grant", 32'(grant), 32'h0);
        check("t5_async_press", 32'(press), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        btn = 4'b0000;
        go(2);  check("t5_tick_e2", 32'(tick), 32'h0);
        go(1);  check("t5_tick_e3", 32'(tick), 32'h1);
        check("t5_press_count", 32'(press_cnt - base), 32'd0);

        // All four held; each served button is released and re-pressed.
        start(4'b1111);
        go(4);  check("t6_grant_first", 32'(grant), 32'h0);
        for (int i = 0; i < 5; i++) begin
            e     = i % 4;
            exp_p = 4'b0001 << e;
            go(12); check("t6_press", 32'(press), 32'(exp_p));
            btn[e] = 1'b0;
            go(16); check("t6_idle", 32'(busy), 32'h0);
            btn[e] = 1'b1;
            if (i < 4) begin
                go(4); check("t6_grant", 32'(grant), 32'((i + 1) % 4));
            end
        end
        check("t6_press_count", 32'(press_cnt - base), 32'd5);
        check("press_onehot", 32'(multi_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btn_utemezo.md
BTN_UTEMEZO -- requirements
Module: btn_utemezo

Interface
REQ-001 Parameter PRESCALE, default 50000, is the number of clk cycles per sample tick (legal range 2..65535).
REQ-002 Parameter STABLE_CNT, default 4, is the number of consecutive equal samples needed to accept a press or a release (legal range 2..15).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn  input  4  raw, asynchronous push-button levels; 1 means pressed.
REQ-006 press  output  4  one-hot, one-clk-cycle pulse per accepted press.
REQ-007 tick  output  1  one-clk-cycle sample strobe, high once every PRESCALE cycles.
REQ-008 busy  output  1  high while a button is granted, i.e. whenever the FSM is not in IDLE.
REQ-009 grant  output  2  index of the currently granted button; holds its last value while in IDLE.

Function
REQ-010 A 16-bit prescaler counts 0..PRESCALE-1 and wraps to 0; tick is high in the cycle the count equals PRESCALE-1.
REQ-011 Each btn bit passes through a 2-flop synchroniser; all decisions use the synchronised value (sbtn).
REQ-012 A single shared stability counter (4 bits) and a single FSM serve all four buttons, one at a time.
REQ-013 The FSM states are IDLE, CHECK and RELEASE; every transition occurs only in a cycle where tick=1.
REQ-014 IDLE, on tick with any sbtn bit set: grant the first set bit searching round-robin from pointer rr, load cnt=1, go to CHECK.
REQ-015 IDLE, on tick with no sbtn bit set: remain in IDLE with no change.
REQ-016 CHECK, on tick with sbtn[grant]=1: cnt increments.
REQ-017 CHECK, when cnt reaches STABLE_CNT: press[grant] is pulsed for exactly one cycle, cnt is cleared to 0, and the FSM goes to RELEASE.
REQ-018 CHECK, on tick with sbtn[grant]=0: the event is a glitch; no pulse, rr=grant+1 (mod 4), go to IDLE.
REQ-019 RELEASE, on tick: sbtn[grant]=0 increments cnt; sbtn[grant]=1 clears cnt to 0.
REQ-020 RELEASE, when cnt reaches STABLE_CNT: rr=grant+1 (mod 4), go to IDLE.
REQ-021 Latency: with grant on tick k, press asserts in the clk cycle after tick k+STABLE_CNT-1.
REQ-022 Buttons that are not granted are ignored, not queued; they are served only if still held after the FSM returns to IDLE.
REQ-023 Simultaneous presses resolve by round-robin from rr, so no button is served twice in a row while another is held.
REQ-024 At most one press bit is ever high, and press never pulses twice for one hold, however long the button is held.

Reset
REQ-025 Asserting rst=0 forces state=IDLE, prescaler=0, cnt=0, rr=0, grant=0, synchronisers=0, press=0, tick=0 and busy=0 immediately, without waiting for a clock edge.
REQ-026 Reset asserted mid-CHECK or mid-RELEASE aborts the operation without emitting a press pulse.
REQ-027 The first tick after reset release occurs PRESCALE cycles after the first clk edge.

Structure
REQ-028 Shared package btn_pkg holds the state encoding (IDLE=2'd0, CHECK=2'd1, RELEASE=2'd2) and the default values of PRESCALE and STABLE_CNT.
REQ-029 The prescaler is a separate sub-module, tick_gen (parameter PRESCALE, ports clk, rst, tick); the FSM, counter and arbiter stay in btn_utemezo.
REQ-030 State encoding 2'd3 is unreachable and SHALL return to IDLE on the next clock.

Verification (PRESCALE=4, STABLE_CNT=4 throughout)
REQ-031 Hold btn=4'b0010 for 40 ticks -> exactly one press=4'b0010 pulse, on the cycle after the 4th tick from grant; busy stays high until 4 low ticks after release.
REQ-032 btn[0] high for 2 ticks then low -> no press pulse, FSM returns to IDLE, rr=1.
REQ-033 btn=4'b1001 held from reset -> press[0] pulses first; after btn[0] is released, press[3] pulses; btn[3] is not lost.
REQ-034 During RELEASE, bounce btn[grant] high on ticks 2 and 3 -> cnt restarts at 0; IDLE is reached only after 4 consecutive low ticks; no second press pulse.
REQ-035 Assert rst=0 mid-CHECK (cnt=3) -> all outputs go to 0 asynchronously; no press pulse; after release the next tick arrives 4 cycles later.
REQ-036 All four buttons held continuously with a release/re-press between services -> presses are granted in order 0,1,2,3,0 under round-robin.
